// File: rtl/jk_ff.sv
// jk_ff: edge-triggered JK flip-flop, WIDTH independent bit-slices sharing one clock,
// one asynchronous reset and one asynchronous set.
//
// Ports:
//   CK  - clock; J/K are sampled on the rising edge only
//   J   - per-slice set/toggle request (WIDTH bits)
//   K   - per-slice clear/toggle request (WIDTH bits)
//   Q   - per-slice registered state (WIDTH bits)
//   RB  - asynchronous active-high reset, forces Q to 0; wins over SB
//   SB  - asynchronous active-high set, forces Q to all-ones
//
// Release of RB/SB is not synchronised: the first rising CK edge that sees both low
// resumes normal JK operation. Clock edges while either is high are ignored.
module jk_ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             CK,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  input  logic             RB,
  input  logic             SB
);

  logic [WIDTH-1:0] q_d;

  // Characteristic equation: set where J pulls a 0 up, keep a 1 unless K clears it.
  // J=K=1 therefore inverts the slice; J=K=0 holds it.
  always_comb begin
    q_d = (J & ~Q) | (~K & Q);
  end

  // RB is tested first so reset wins when both asynchronous controls are high.
  always_ff @(posedge CK or posedge RB or posedge SB) begin
    if (RB) begin
      Q <= '0;
    end else if (SB) begin
      Q <= '1;
    end else begin
      Q <= q_d;
    end
  end

endmodule

// File: tb/tb_jk_ff.sv
// tb_jk_ff: scoreboard bench for jk_ff (WIDTH=4). The stimulus process updates a
// truth-table reference model and pushes the expected Q into a queue; a separate
// monitor process pops and compares each entry when notified.
module tb_jk_ff;

  localparam int unsigned W = 4;

  logic         CK;
  logic [W-1:0] J;
  logic [W-1:0] K;
  logic [W-1:0] Q;
  logic         RB;
  logic         SB;

  jk_ff #(.WIDTH(W)) dut (
    .CK(CK),
    .J (J),
    .K (K),
    .Q (Q),
    .RB(RB),
    .SB(SB)
  );

  initial CK = 1'b0;
  always #10 CK = ~CK;

  typedef struct {
    logic [W-1:0] exp;
    string        name;
  } exp_t;

  exp_t         sb_q[$];
  event         check_ev;
  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] model;

  // Monitor: compares every queued expectation against the DUT output.
  initial begin
    forever begin
      @(check_ev);
      while (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        checks++;
        if (Q !== e.exp) begin
          errors++;
          $display("FAIL %s: Q=%b expected=%b at %0t", e.name, Q, e.exp, $time);
        end
      end
    end
  end

  task automatic expect_q(input string name);
    exp_t e;
    e.exp  = model;
    e.name = name;
    sb_q.push_back(e);
    -> check_ev;
  endtask

  // Reference: plain JK truth table applied slice by slice.
  function automatic logic [W-1:0] jk_next(input logic [W-1:0] q, input logic [W-1:0] j,
                                           input logic [W-1:0] k);
    logic [W-1:0] r;
    for (int b = 0; b < W; b++) begin
      case ({j[b], k[b]})
        2'b00:   r[b] = q[b];
        2'b01:   r[b] = 1'b0;
        2'b10:   r[b] = 1'b1;
        default: r[b] = ~q[b];
      endcase
    end
    return r;
  endfunction

  // Change J/K on the falling edge, well away from the sampling edge.
  task automatic drive(input logic [W-1:0] j, input logic [W-1:0] k);
    @(negedge CK);
    J = j;
    K = k;
  endtask

  // One rising edge: model follows the table unless an override is active.
  task automatic step(input string name);
    logic [W-1:0] jv;
    logic [W-1:0] kv;
    jv = J;
    kv = K;
    @(posedge CK);
    if (!RB && !SB) model = jk_next(model, jv, kv);
    else if (RB) model = '0;
    else model = '1;
    #1;
    expect_q(name);
  endtask

  initial begin
    RB = 1'b0;
    SB = 1'b0;
    J  = '0;
    K  = '0;
    model = '0;

    // Reset with the clock idle.
    #2 RB = 1'b1;
    #1 model = '0;
    expect_q("reset_async");
    #2 RB = 1'b0;
    step("reset_hold0");
    step("reset_hold1");

    // Set / hold / clear on all slices.
    drive('1, '0);
    step("set");
    drive('0, '0);
    step("hold0");
    step("hold1");
    drive('0, '1);
    step("clear");

    // Toggle: changes on rising edges only.
    drive('1, '1);
    for (int i = 0; i < 4; i++) begin
      step("toggle_rise");
      @(negedge CK);
      #1 expect_q("toggle_fall");
    end

    // Async override mid-cycle during toggling.
    step("toggle_pre");
    #4 SB = 1'b1;
    #1 model = '1;
    expect_q("set_async");
    step("set_held0");
    step("set_held1");
    #4 RB = 1'b1;
    #1 model = '0;
    expect_q("reset_priority");
    #2 RB = 1'b0;
    SB = 1'b0;
    #1 expect_q("release_keep");
    step("toggle_resume");

    // Simultaneity: J rises in the edge timestep; the edge must see the old J.
    drive('0, '0);
    model = '0;
    drive('0, '1);
    step("clear_before_sim");
    drive('0, '0);
    @(posedge CK);
    J <= '1;  // nonblocking so the DUT's edge sees the pre-edge value
    #1 expect_q("sim_edge");
    step("sim_next");

    // Independent slices: 0011 -> J=1010,K=0110 -> 1001.
    drive(4'b0011, 4'b1100);
    step("load_0011");
    drive(4'b1010, 4'b0110);
    step("slices_1001");
    if (model !== 4'b1001) begin
      errors++;
      $display("FAIL slices_model: model=%b expected=1001", model);
    end
    checks++;

    // Randomized J/K with occasional asynchronous pulses.
    for (int i = 0; i < 150; i++) begin
      drive(W'($urandom), W'($urandom));
      step("rand_edge");
      if ($urandom_range(0, 7) == 0) begin
        int unsigned r;
        r = $urandom_range(1, 3);
        #4;
        RB = r[0];
        SB = r[1];
        #1 model = RB ? '0 : '1;
        expect_q("rand_async");
        #2;
        RB = 1'b0;
        SB = 1'b0;
        #1 expect_q("rand_release");
      end
    end

    // Drain the scoreboard with a bounded wait.
    for (int t = 0; t < 10 && sb_q.size() > 0; t++) #1;
    if (sb_q.size() > 0) begin
      $display("FAIL drain: pending=%0d expected=0", sb_q.size());
      errors += sb_q.size();
      checks += sb_q.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jk_ff.md
# jk_ff

Edge-triggered JK flip-flop with asynchronous reset and asynchronous set, used as a general-purpose storage/toggle element in small sequential blocks such as counters, dividers and control latches. One rising clock edge samples J and K and updates Q per the JK truth table. RB and SB override the clock path at any time.

## Interface
Parameters:
- WIDTH, default 1: number of independent JK bit-slices. Every port except CK, RB and SB is WIDTH bits wide, and the slices share CK, RB and SB.

Ports, in positional order CK, J, K, Q, RB, SB:
- CK  input  1  clock; all synchronous activity is on the rising edge.
- RB  input  1  reset, asynchronous and active-high; forces Q to 0.
- SB  input  1  set, asynchronous and active-high; forces Q to all-ones.
- J  input  WIDTH  set/toggle request per slice.
- K  input  WIDTH  clear/toggle request per slice.
- Q  output  WIDTH  registered state.

## Operation
- Per slice, on each rising CK edge when RB=0 and SB=0:
  - J=0, K=0: hold; Q keeps its value.
  - J=0, K=1: Q becomes 0.
  - J=1, K=0: Q becomes 1.
  - J=1, K=1: Q becomes ~Q (toggle).
- RB=1: Q is 0 immediately, independent of CK, J and K, and stays 0 while RB is held.
- SB=1 with RB=0: Q is all-ones immediately and stays all-ones while SB is held.
- RB=1 and SB=1 together: reset wins and Q=0. There is no illegal or indeterminate state.
- Reset value of Q is 0. Before the first reset or set assertion, Q is undefined (X in simulation). Benches must reset first.
- Slices are fully independent. There are no cross-slice carries.
- Q drives no combinational path from J or K. It changes only on a CK rising edge or on assertion of RB or SB.

## Timing
- Latency: J and K sampled at rising edge n appear on Q immediately after edge n. There is no extra pipeline stage.
- RB and SB act without waiting for a clock. Q responds in the same delta or timestep as the asserting edge of RB or SB.
- Release of RB or SB is not synchronized. The first rising CK edge with both RB and SB deasserted resumes normal JK operation.
- Edges while RB or SB is asserted are ignored, and no toggle is "remembered".
- If J and K change at the same timestep as a CK rising edge, the pre-edge values are used, which is standard nonblocking register semantics.
- The falling edge of CK has no effect.
- With J=K=1 held, Q toggles on every rising edge: a divide-by-2 of CK.

## Test plan
- Reset: Q=X, pulse RB=1 with CK idle -> Q=0 at once. Release RB with J=K=0 and run 2 edges -> Q stays 0.
- Set/load: from Q=0, J=1, K=0 -> Q=1 after the next rising edge. Then J=0, K=0 -> Q holds 1 for 2 edges. Then J=0, K=1 -> Q=0 after the next edge.
- Toggle: J=K=1 from Q=0 with a 20 ns clock period -> Q=1,0,1,0 on successive rising edges. Q has a 40 ns period and no change on falling edges.
- Async override: during toggling, raise SB mid-cycle -> Q=1 immediately and holds across 2 edges. Raise RB as well -> Q=0 (reset priority). Drop both -> toggling resumes from 0 at the next rising edge.
- Simultaneity: change J from 0 to 1 in the same timestep as the rising edge with K=0 and Q=0 -> Q stays 0 at that edge and becomes 1 at the following edge.
- WIDTH=4: J=4'b1010, K=4'b0110 from Q=4'b0011 -> Q=4'b1001 after one edge (slices hold, set, clear and toggle independently).
